// File: rtl/pc_steer_if.sv
// Decode/branch-resolution to PC-steering bundle: resolved control-flow op in, PC drive and RAS status out.
interface pc_steer_if;
  logic signed [31:0] pc;
  logic               stall;
  logic               br_valid;
  logic        [2:0]  br_kind;
  logic               br_taken;
  logic signed [31:0] br_offset;
  logic signed [31:0] br_target;
  logic signed [31:0] pcsrc;
  logic               JF;
  logic               flush;
  logic               ras_ovf;
  logic               ras_udf;

  modport master (
    output pc, stall, br_valid, br_kind, br_taken, br_offset, br_target,
    input  pcsrc, JF, flush, ras_ovf, ras_udf
  );

  modport slave (
    input  pc, stall, br_valid, br_kind, br_taken, br_offset, br_target,
    output pcsrc, JF, flush, ras_ovf, ras_udf
  );
endinterface

// File: rtl/pc_steer.sv
// PC steering: boot vector, step/stall, branch, call/return via a circular RAS; flush after each redirect.
// Outputs are combinational from state and inputs (0-cycle redirect); stall holds the PC, a branch beats a stall.
module pc_steer #(
  parameter logic signed [31:0] STEP      = 32'sd4,
  parameter logic        [31:0] RESET_VEC = 32'h0,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  pc_steer_if.slave  bus
);

  localparam int              PW       = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int              CW       = PW + 1;
  localparam logic [CW-1:0]   FULL_CNT = CW'(RAS_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     ras_q [RAS_DEPTH];
  logic [31:0]     ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;

  logic            is_redirect;
  logic            ras_full;
  logic            ras_empty;
  logic [PW-1:0]   top_idx;
  logic [31:0]     link;
  logic [31:0]     pcsrc_c;
  logic            jf_c;
  logic            flush_c;

  always_comb begin
    is_redirect = bus.br_valid &&
                  (((bus.br_kind == 3'd0) && bus.br_taken) ||
                   ((bus.br_kind >= 3'd1) && (bus.br_kind <= 3'd4)));
    ras_full    = (cnt_q == FULL_CNT);
    ras_empty   = (cnt_q == '0);
    top_idx     = ptr_q - PW'(1);
    link        = bus.pc + STEP;
  end

  always_comb begin
    state_d = state_q;
    ras_d   = ras_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    pcsrc_c = STEP;
    jf_c    = 1'b0;
    flush_c = 1'b0;

    case (state_q)
      S_BOOT: begin
        pcsrc_c = RESET_VEC;
        jf_c    = 1'b1;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (is_redirect) begin
          state_d = S_FLUSH;
          case (bus.br_kind)
            3'd0: begin
              pcsrc_c = bus.br_offset;
            end
            3'd2: begin
              pcsrc_c       = bus.br_target;
              jf_c          = 1'b1;
              // ptr always names the next free slot; when full it is also the oldest entry
              ras_d[ptr_q]  = link;
              ptr_d         = ptr_q + PW'(1);
              if (ras_full) begin
                ovf_d = 1'b1;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
            3'd3: begin
              jf_c = 1'b1;
              if (!ras_empty) begin
                pcsrc_c = ras_q[top_idx];
                ptr_d   = top_idx;
                cnt_d   = cnt_q - CW'(1);
              end else begin
                pcsrc_c = bus.br_target;
                udf_d   = 1'b1;
              end
            end
            default: begin
              pcsrc_c = bus.br_target;
              jf_c    = 1'b1;
            end
          endcase
        end else if (bus.stall) begin
          pcsrc_c = '0;
        end
      end

      S_FLUSH: begin
        flush_c = 1'b1;
        state_d = S_RUN;
        if (bus.stall) begin
          pcsrc_c = '0;
        end
      end

      default: begin
        pcsrc_c = RESET_VEC;
        jf_c    = 1'b1;
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_BOOT;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign bus.pcsrc   = pcsrc_c;
  assign bus.JF      = jf_c;
  assign bus.flush   = flush_c;
  assign bus.ras_ovf = ovf_q;
  assign bus.ras_udf = udf_q;

endmodule

// File: tb/tb_pc_steer.sv
// Bench for pc_steer: directed table, call/return and reset sequences, then random ops against a queue-based model.
module tb_pc_steer;

  localparam logic [31:0] RVEC  = 32'h100;
  localparam logic [31:0] STEPV = 32'd4;
  localparam int          DEPTH = 4;

  logic CLOCK = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLOCK = ~CLOCK;

  pc_steer_if bus ();

  pc_steer #(.STEP(32'sd4), .RESET_VEC(32'h100), .RAS_DEPTH(DEPTH)) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;

  // environment PC plus reference model state: phase 0 boot, 1 run, 2 flush
  logic [31:0] pc_reg = 32'h0;
  int          m_phase = 0;
  logic [31:0] m_ras[$];
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  logic [31:0] o_src;
  logic        o_jf;
  logic        o_fl;
  logic [31:0] pc_at;

  typedef struct {
    logic        st;
    logic        bv;
    logic [2:0]  k;
    logic        tk;
    logic [31:0] off;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic [31:0] e_src;
    logic        e_jf;
    logic        e_fl;
  } vec_t;

  vec_t tv[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at posedge+1: drives one cycle, compares against the model at mid-cycle, commits at the edge.
  task automatic apply(input logic st, input logic bv, input logic [2:0] k, input logic tk,
                       input logic [31:0] off, input logic [31:0] tgt);
    logic [31:0] e_src;
    logic        e_jf, e_fl, push, pop, udf_set;
    int          nph;
    bus.pc        = pc_reg;
    bus.stall     = st;
    bus.br_valid  = bv;
    bus.br_kind   = k;
    bus.br_taken  = tk;
    bus.br_offset = off;
    bus.br_target = tgt;
    #4;
    e_src = STEPV; e_jf = 1'b0; e_fl = 1'b0; nph = 1;
    push = 1'b0; pop = 1'b0; udf_set = 1'b0;
    if (m_phase == 0) begin
      e_src = RVEC; e_jf = 1'b1;
    end else if (m_phase == 2) begin
      e_fl  = 1'b1;
      e_src = st ? 32'h0 : STEPV;
    end else if (bv && ((k == 3'd0 && tk) || (k >= 3'd1 && k <= 3'd4))) begin
      nph = 2;
      if (k == 3'd0) begin
        e_src = off;
      end else if (k == 3'd3) begin
        e_jf = 1'b1;
        if (m_ras.size() > 0) begin
          e_src = m_ras[$]; pop = 1'b1;
        end else begin
          e_src = tgt; udf_set = 1'b1;
        end
      end else begin
        e_src = tgt; e_jf = 1'b1; push = (k == 3'd2);
      end
    end else begin
      e_src = st ? 32'h0 : STEPV;
    end
    chk("pcsrc", bus.pcsrc, e_src);
    chk("JF", bus.JF, e_jf);
    chk("flush", bus.flush, e_fl);
    chk("ras_ovf", bus.ras_ovf, m_ovf);
    chk("ras_udf", bus.ras_udf, m_udf);
    o_src = bus.pcsrc; o_jf = bus.JF; o_fl = bus.flush; pc_at = pc_reg;
    @(posedge CLOCK);
    pc_reg  = o_jf ? o_src : pc_reg + o_src;
    m_phase = nph;
    if (push) begin
      m_ras.push_back(pc_at + STEPV);
      if (m_ras.size() > DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
    end
    if (pop) void'(m_ras.pop_back());
    if (udf_set) m_udf = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] links[5];

    //          st    bv    k     tk    off          tgt          e_pc          e_src         jf    fl
    tv[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h0,        32'h100,      1'b1, 1'b0};
    tv[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h100,      32'h4,        1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h104,      32'h4,        1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h108,      32'h0,        1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h108,      32'h0,        1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h108,      32'h0,        1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 3'd1, 1'b0, 32'h0,       32'h400,     32'h108,      32'h400,      1'b1, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 3'd1, 1'b0, 32'h0,       32'h999,     32'h400,      32'h4,        1'b0, 1'b1};
    tv[8]  = '{1'b0, 1'b1, 3'd1, 1'b0, 32'h0,       32'h120,     32'h404,      32'h120,      1'b1, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h120,      32'h0,        1'b0, 1'b1};
    tv[10] = '{1'b0, 1'b1, 3'd0, 1'b1, 32'hFFFFFFF8, 32'h0,      32'h120,      32'hFFFFFFF8, 1'b0, 1'b0};
    tv[11] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h118,      32'h4,        1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b1, 3'd0, 1'b0, 32'hFFFFFFF8, 32'h0,      32'h11C,      32'h4,        1'b0, 1'b0};
    tv[13] = '{1'b0, 1'b1, 3'd6, 1'b1, 32'h40,      32'h800,     32'h120,      32'h4,        1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b1, 3'd1, 1'b0, 32'h0,       32'h200,     32'h124,      32'h200,      1'b1, 1'b0};
    tv[15] = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h200,      32'h0,        1'b0, 1'b1};
    tv[16] = '{1'b0, 1'b1, 3'd2, 1'b0, 32'h0,       32'h500,     32'h200,      32'h500,      1'b1, 1'b0};
    tv[17] = '{1'b0, 1'b1, 3'd3, 1'b0, 32'h0,       32'h777,     32'h500,      32'h4,        1'b0, 1'b1};
    tv[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h504,      32'h4,        1'b0, 1'b0};
    tv[19] = '{1'b0, 1'b1, 3'd3, 1'b0, 32'h0,       32'h666,     32'h508,      32'h204,      1'b1, 1'b0};
    tv[20] = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,       32'h0,       32'h204,      32'h4,        1'b0, 1'b1};

    bus.pc = '0; bus.stall = 1'b0; bus.br_valid = 1'b0; bus.br_kind = '0;
    bus.br_taken = 1'b0; bus.br_offset = '0; bus.br_target = '0;

    // held in reset
    #3;
    chk("rst_pcsrc", bus.pcsrc, RVEC);
    chk("rst_JF", bus.JF, 1'b1);
    chk("rst_flush", bus.flush, 1'b0);
    chk("rst_ovf", bus.ras_ovf, 1'b0);
    chk("rst_udf", bus.ras_udf, 1'b0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;

    for (int i = 0; i < 21; i++) begin
      apply(tv[i].st, tv[i].bv, tv[i].k, tv[i].tk, tv[i].off, tv[i].tgt);
      chk($sformatf("tv%0d_pc", i), pc_at, tv[i].e_pc);
      chk($sformatf("tv%0d_pcsrc", i), o_src, tv[i].e_src);
      chk($sformatf("tv%0d_JF", i), o_jf, tv[i].e_jf);
      chk($sformatf("tv%0d_flush", i), o_fl, tv[i].e_fl);
    end

    // signed wrap of the stepped PC
    apply(1'b0, 1'b1, 3'd1, 1'b0, 32'h0, 32'h7FFFFFFC);
    apply(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pre", pc_reg, 32'h7FFFFFFC);
    apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    chk("wrap_pc", pc_reg, 32'h80000000);
    chk("wrap_ovf", bus.ras_ovf, 1'b0);
    chk("wrap_udf", bus.ras_udf, 1'b0);

    // five nested calls into a four-deep stack, then five returns
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 3'd2, 1'b0, 32'h0, 32'h1000 * (i + 1));
      links[i] = pc_at + STEPV;
      apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    end
    chk("ovf_set", bus.ras_ovf, 1'b1);
    chk("ovf_no_udf", bus.ras_udf, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 3'd3, 1'b0, 32'h0, 32'hDEAD0000);
      chk($sformatf("ret%0d_src", i), o_src, links[4 - i]);
      chk($sformatf("ret%0d_JF", i), o_jf, 1'b1);
      apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    end
    apply(1'b0, 1'b1, 3'd3, 1'b0, 32'h0, 32'hABC0);
    chk("ret_empty_src", o_src, 32'hABC0);
    apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    chk("udf_set", bus.ras_udf, 1'b1);

    // reset pulsed in the middle of a FLUSH cycle
    apply(1'b0, 1'b1, 3'd2, 1'b0, 32'h0, 32'h3000);
    bus.stall = 1'b0; bus.br_valid = 1'b0;
    #1;
    chk("pre_rst_flush", bus.flush, 1'b1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("midrst_pcsrc", bus.pcsrc, RVEC);
    chk("midrst_JF", bus.JF, 1'b1);
    chk("midrst_flush", bus.flush, 1'b0);
    chk("midrst_ovf", bus.ras_ovf, 1'b0);
    chk("midrst_udf", bus.ras_udf, 1'b0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    m_phase = 0; m_ras.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    pc_reg = RVEC;
    apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);
    apply(1'b0, 1'b1, 3'd3, 1'b0, 32'h0, 32'h5550);
    chk("postrst_ret", o_src, 32'h5550);
    apply(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
            1'($urandom), 32'($urandom_range(0, 64)) * 4 - 32'd128, $urandom & 32'hFFFFFFFC);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
